core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 Parameter N, default 16, base word width; point indices are 2N bits.
REQ-002 Parameter CORE_NUMBER, default 16, number of validator cores served (2..64).
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a point-cloud pass.
REQ-006 pause  input  1  high = freeze dispatch; all state held.
REQ-007 point_cloud_size  input  2N  number of points in the pass; sampled on accepted start.
REQ-008 core_req  input  CORE_NUMBER  bit i high = core i finished its point.
REQ-009 core_outlier  input  CORE_NUMBER  bit i qualifies core_req[i]; high = point was an outlier.
REQ-010 grant  output  CORE_NUMBER  one-hot, one-cycle pulse; resets and loads the granted core.
REQ-011 load_pos  output  2N  index of the point loaded into the granted core; doubles as cache read address.
REQ-012 out_valid  output  1  outlier index available.
REQ-013 out_ready  input  1  downstream FIFO accepts out_pos.
REQ-014 out_pos  output  2N  outlier point index.
REQ-015 outlier_count  output  2N  outliers emitted in current pass.
REQ-016 busy  output  1  high in LOAD, RUN, DRAIN.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DRAIN, DONE; start accepted only in IDLE or DONE, ignored otherwise.
REQ-019 Accepted start: next_pos<=0, active<=0, outlier_count<=0; go LOAD, or DONE directly when point_cloud_size==0.
REQ-020 LOAD: one grant per cycle to cores 0,1,2,... in order, load_pos=next_pos, active[i]<=1, next_pos++; leave to RUN when next_pos reaches min(CORE_NUMBER, point_cloud_size).
REQ-021 RUN: eligible set = core_req & active & ~grant_last (core granted last cycle is ineligible).
REQ-022 RUN: at most one grant per cycle, round-robin starting at core after last granted core; registered, grant appears one cycle after core_req sampled.
REQ-023 Grant issued only when out slot free: out_valid==0 or out_ready==1 in that cycle.
REQ-024 On service of core g with core_outlier[g]==1: out_pos<=pos_reg[g], out_valid<=1, outlier_count++.
REQ-025 On service with next_pos<point_cloud_size: grant[g] pulse, load_pos<=next_pos, pos_reg[g]<=next_pos, next_pos++.
REQ-026 On service with next_pos>=point_cloud_size: no grant pulse, active[g]<=0 (core retired).
REQ-027 RUN -> DRAIN when next_pos>=point_cloud_size; DRAIN continues servicing/retiring per REQ-021..026.
REQ-028 DRAIN -> DONE when active==0 and out_valid==0.
REQ-029 out_valid held with out_pos stable until out_ready; clears on out_ready unless refilled same cycle.
REQ-030 pause==1: no grants, no state change, out handshake still completes if out_ready.
REQ-031 core_req for an inactive core ignored; core_outlier ignored when core_req low.
REQ-032 grant and load_pos zero when no grant issued; grant never multi-hot.
REQ-033 done held until next accepted start; counters 2N bits, no wrap within a pass.

Reset
REQ-034 reset low: state IDLE; grant, load_pos, out_valid, out_pos, outlier_count, busy, done, active, next_pos, round-robin pointer all 0, immediately and asynchronously.
REQ-035 reset mid-pass aborts the pass; no grant or out_valid after release until next start.

Verification (CORE_NUMBER=4)
REQ-036 size=10, start -> grants 0001,0010,0100,1000 on 4 consecutive cycles, load_pos 0..3, then RUN.
REQ-037 RUN, core_req=1111 held, no outliers -> grants rotate 0001,0010,0100,1000, load_pos 4..7, one per cycle.
REQ-038 core 2 outlier (pos_reg 2), out_ready=0 for 5 cycles -> out_valid=1, out_pos=2 stable, zero grants until out_ready=1.
REQ-039 size=2 -> LOAD grants only cores 0,1; after both report, DONE with outlier_count correct, cores 2,3 never granted.
REQ-040 size=0, start -> DONE next cycle, no grant, no out_valid.
REQ-041 pause=1 mid-RUN with requests pending -> no grants while paused; reset low mid-pass -> all outputs 0 immediately.

Source files
------------

// File: rtl/core_scheduler.sv
// Point-cloud dispatch scheduler: loads validator cores in order, then reissues points
// round-robin as cores report back, forwarding outlier indices through a one-entry out slot.
module core_scheduler #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic [2*N-1:0]         point_cloud_size,
  input  logic [CORE_NUMBER-1:0] core_req,
  input  logic [CORE_NUMBER-1:0] core_outlier,
  output logic [CORE_NUMBER-1:0] grant,
  output logic [2*N-1:0]         load_pos,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_pos,
  output logic [2*N-1:0]         outlier_count,
  output logic                   busy,
  output logic                   done
);
  localparam int PW = 2*N;
  localparam int CW = $clog2(CORE_NUMBER);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                           state_q, state_d;
  logic [PW-1:0]                    size_q, size_d;
  logic [PW-1:0]                    next_pos_q, next_pos_d;
  logic [CORE_NUMBER-1:0]           active_q, active_d;
  logic [CW-1:0]                    rr_q, rr_d;
  logic [CORE_NUMBER-1:0][PW-1:0]   pos_reg_q, pos_reg_d;
  logic [CORE_NUMBER-1:0]           grant_q, grant_d;
  logic [PW-1:0]                    load_pos_q, load_pos_d;
  logic                             out_valid_q, out_valid_d;
  logic [PW-1:0]                    out_pos_q, out_pos_d;
  logic [PW-1:0]                    cnt_q, cnt_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic [CORE_NUMBER-1:0] elig, hi_mask, sel;
  logic                   pick_vld;
  logic [CW-1:0]          pick;
  logic [CW-1:0]          load_idx;
  logic [PW-1:0]          load_lim;
  logic                   slot_free;

  // Round-robin pick: prefer eligible cores above the last granted one, else wrap to the lowest.
  always_comb begin
    elig     = core_req & active_q & ~grant_q;
    hi_mask  = '0;
    pick_vld = |elig;
    pick     = '0;
    for (int i = 0; i < CORE_NUMBER; i++) hi_mask[i] = (CW'(i) > rr_q);
    sel = (|(elig & hi_mask)) ? (elig & hi_mask) : elig;
    for (int i = CORE_NUMBER-1; i >= 0; i--) begin
      if (sel[i]) pick = CW'(i);
    end
  end

  assign load_idx  = next_pos_q[CW-1:0];
  assign load_lim  = (size_q < PW'(CORE_NUMBER)) ? size_q : PW'(CORE_NUMBER);
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    next_pos_d  = next_pos_q;
    active_d    = active_q;
    rr_d        = rr_q;
    pos_reg_d   = pos_reg_q;
    grant_d     = '0;
    load_pos_d  = '0;
    out_valid_d = out_valid_q;
    out_pos_d   = out_pos_q;
    cnt_d       = cnt_q;

    // The downstream handshake completes even while paused.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (!pause) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            size_d     = point_cloud_size;
            next_pos_d = '0;
            active_d   = '0;
            cnt_d      = '0;
            state_d    = (point_cloud_size == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          grant_d[load_idx]   = 1'b1;
          load_pos_d          = next_pos_q;
          pos_reg_d[load_idx] = next_pos_q;
          active_d[load_idx]  = 1'b1;
          rr_d                = load_idx;
          next_pos_d          = next_pos_q + PW'(1);
          if (next_pos_d >= load_lim) state_d = RUN;
        end
        RUN, DRAIN: begin
          if (slot_free && pick_vld) begin
            if (core_outlier[pick]) begin
              out_pos_d   = pos_reg_q[pick];
              out_valid_d = 1'b1;
              cnt_d       = cnt_q + PW'(1);
            end
            if (next_pos_q < size_q) begin
              grant_d[pick]   = 1'b1;
              load_pos_d      = next_pos_q;
              pos_reg_d[pick] = next_pos_q;
              next_pos_d      = next_pos_q + PW'(1);
              rr_d            = pick;
            end else begin
              active_d[pick] = 1'b0;
            end
          end
          if (state_q == RUN) begin
            if (next_pos_d >= size_q) state_d = DRAIN;
          end else if (active_q == '0 && !out_valid_q) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      next_pos_q  <= '0;
      active_q    <= '0;
      rr_q        <= '0;
      pos_reg_q   <= '0;
      grant_q     <= '0;
      load_pos_q  <= '0;
      out_valid_q <= 1'b0;
      out_pos_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      next_pos_q  <= next_pos_d;
      active_q    <= active_d;
      rr_q        <= rr_d;
      pos_reg_q   <= pos_reg_d;
      grant_q     <= grant_d;
      load_pos_q  <= load_pos_d;
      out_valid_q <= out_valid_d;
      out_pos_q   <= out_pos_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign grant         = grant_q;
  assign load_pos      = load_pos_q;
  assign out_valid     = out_valid_q;
  assign out_pos       = out_pos_q;
  assign outlier_count = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler with four cores: a vector table for the main pass
// plus hand sequences for pause, busy-time start and mid-pass reset.
module tb_core_scheduler;
  localparam int N  = 16;
  localparam int CN = 4;
  localparam int PW = 2*N;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          out_ready = 1'b1;
  logic [PW-1:0] point_cloud_size = '0;
  logic [CN-1:0] core_req = '0;
  logic [CN-1:0] core_outlier = '0;
  logic [CN-1:0] grant;
  logic [PW-1:0] load_pos, out_pos, outlier_count;
  logic          out_valid, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  core_scheduler #(.N(N), .CORE_NUMBER(CN)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .point_cloud_size(point_cloud_size), .core_req(core_req), .core_outlier(core_outlier),
    .grant(grant), .load_pos(load_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .outlier_count(outlier_count), .busy(busy), .done(done)
  );

  typedef struct {
    logic          st;
    logic [PW-1:0] sz;
    logic [CN-1:0] rq, ol;
    logic          rd;
    logic [CN-1:0] g;
    logic [PW-1:0] lp;
    logic          ov;
    logic [PW-1:0] op, cnt;
    logic          bs, dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [PW-1:0] sz, input logic [CN-1:0] rq,
                              input logic [CN-1:0] ol, input logic rd, input logic [CN-1:0] g,
                              input logic [PW-1:0] lp, input logic ov, input logic [PW-1:0] op,
                              input logic [PW-1:0] cnt, input logic bs, input logic dn);
    vec_t v;
    v.st = st; v.sz = sz; v.rq = rq; v.ol = ol; v.rd = rd; v.g = g;
    v.lp = lp; v.ov = ov; v.op = op; v.cnt = cnt; v.bs = bs; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [CN-1:0] g, input logic [PW-1:0] lp,
                         input logic ov, input logic [PW-1:0] op, input logic [PW-1:0] cnt,
                         input logic bs, input logic dn);
    chk({tag, " grant"}, 64'(grant), 64'(g));
    chk({tag, " load_pos"}, 64'(load_pos), 64'(lp));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, " out_pos"}, 64'(out_pos), 64'(op));
    chk({tag, " outlier_count"}, 64'(outlier_count), 64'(cnt));
    chk({tag, " busy"}, 64'(busy), 64'(bs));
    chk({tag, " done"}, 64'(done), 64'(dn));
  endtask

  initial begin
    // Pass of 10 points: load, outlier with stalled sink, rotation, drain.
    tbl.push_back(mk(1, 10, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 10, 4'h0, 4'h0, 1, 4'(1 << k), PW'(k), 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 10, 4'h4, 4'h4, 0, 4'h4, 4, 1, 2, 1, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 10, 4'hF, 4'h0, 0, 4'h0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h0, 1, 4'h8, 5, 0, 2, 1, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 10, 4'hF, 4'h0, 1, 4'(1 << k), PW'(6 + k), 0, 2, 1, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h2, 1, 4'h0, 0, 0, 2, 1, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h2, 1, 4'h0, 0, 1, 7, 2, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h2, 1, 4'h0, 0, 0, 7, 2, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h2, 1, 4'h0, 0, 0, 7, 2, 1, 0));
    tbl.push_back(mk(0, 10, 4'hF, 4'h2, 1, 4'h0, 0, 0, 7, 2, 0, 1));
    tbl.push_back(mk(0, 10, 4'h0, 4'h0, 1, 4'h0, 0, 0, 7, 2, 0, 1));
    // Two points: only cores 0 and 1 ever loaded, requests from 2 and 3 ignored.
    tbl.push_back(mk(1, 2, 4'h0, 4'h0, 1, 4'h0, 0, 0, 7, 0, 1, 0));
    tbl.push_back(mk(0, 2, 4'h0, 4'h0, 1, 4'h1, 0, 0, 7, 0, 1, 0));
    tbl.push_back(mk(0, 2, 4'h0, 4'h0, 1, 4'h2, 1, 0, 7, 0, 1, 0));
    tbl.push_back(mk(0, 2, 4'hF, 4'h5, 1, 4'h0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 2, 4'hF, 4'h5, 1, 4'h0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 2, 4'hF, 4'h5, 1, 4'h0, 0, 0, 0, 1, 0, 1));
    // Empty cloud goes straight to DONE.
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 1));

    #3;
    chk_all("reset", '0, '0, 0, '0, '0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st; point_cloud_size = tbl[i].sz; core_req = tbl[i].rq;
      core_outlier = tbl[i].ol; out_ready = tbl[i].rd;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].g, tbl[i].lp, tbl[i].ov, tbl[i].op,
              tbl[i].cnt, tbl[i].bs, tbl[i].dn);
    end

    // Pause mid-RUN with an outlier pending in the out slot.
    start = 1'b1; point_cloud_size = 20; core_req = '0; core_outlier = '0; out_ready = 1'b1;
    tick();
    chk("p_start busy", 64'(busy), 64'd1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("p_load%0d grant", k), 64'(grant), 64'(1 << k));
    end
    core_req = 4'h2; core_outlier = 4'h2; out_ready = 1'b0;
    tick();
    chk_all("p_outlier", 4'h2, 4, 1, 1, 1, 1, 0);
    pause = 1'b1; core_req = 4'hF; core_outlier = '0; out_ready = 1'b1;
    tick();
    chk_all("p_pause0", 4'h0, 0, 0, 1, 1, 1, 0);
    for (int k = 1; k < 3; k++) begin
      tick();
      chk($sformatf("p_pause%0d grant", k), 64'(grant), 64'd0);
      chk($sformatf("p_pause%0d busy", k), 64'(busy), 64'd1);
    end
    pause = 1'b0;
    tick();
    chk_all("p_resume", 4'h4, 5, 0, 1, 1, 1, 0);
    // Start while busy is ignored; dispatch carries on.
    start = 1'b1; point_cloud_size = 0;
    tick();
    chk_all("p_busy_start", 4'h8, 6, 0, 1, 1, 1, 0);
    start = 1'b0;

    // Asynchronous reset between clock edges clears everything at once.
    #2 reset = 1'b0;
    #1 chk_all("async_reset", '0, '0, 0, '0, '0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    core_req = 4'hF; core_outlier = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("post_reset%0d", k), '0, '0, 0, '0, '0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
